// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and the shared memory port.
// Provides the MEM_STORE* memory codes when defs.sv has not already supplied them.
`timescale 1ns/1ps

`ifndef MEM_STORE1
`define MEM_STORE1 4'h5
`endif
`ifndef MEM_STORE2
`define MEM_STORE2 4'h6
`endif
`ifndef MEM_STORE4
`define MEM_STORE4 4'h7
`endif

interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic [3:0]  d_ctrl;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic [3:0]  mem_ctrl;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_ctrl, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_ctrl, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_ctrl, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_ctrl, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-port word memory; sub-word stores via read-modify-write.
// MEM_ARB_RR_EN selects round-robin arbitration; undefined gives fixed data-over-fetch priority.
`timescale 1ns/1ps

module mem_arbiter (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int NUM_LANES = 4;

    typedef enum logic [0:0] {IDLE, RMW_WR} state_t;

    state_t      state, state_nx;
    logic        gnt_i, gnt_d;
    logic        d_win;
    logic        d_st4, d_sub, d_load;
    logic [3:0]  mem_ctrl;
    logic [31:0] mem_addr, mem_wdata;

    logic        if_rvalid, d_rvalid;
    logic [31:0] if_rdata, d_rdata;

    logic [31:0] lat_addr, lat_word;
    logic [15:0] lat_wdata;
    logic        lat_byte;
    logic [NUM_LANES-1:0] lane_sel;
    logic [31:0] merged;

    assign d_st4  = (bus.d_ctrl == `MEM_STORE4);
    assign d_sub  = (bus.d_ctrl == `MEM_STORE1) || (bus.d_ctrl == `MEM_STORE2);
    assign d_load = !d_st4 && !d_sub;

`ifdef MEM_ARB_RR_EN
    // last_d=1 means data was granted most recently; fetch wins the next tie.
    logic last_d;
    assign d_win = !(bus.if_req && last_d);

    always_ff @(posedge clk) begin
        if (rst)        last_d <= 1'b0;
        else if (gnt_d) last_d <= 1'b1;
        else if (gnt_i) last_d <= 1'b0;
    end
`else
    assign d_win = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        gnt_i     = 1'b0;
        gnt_d     = 1'b0;
        mem_ctrl  = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = bus.d_wdata;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (bus.d_req && d_win) begin
                        gnt_d    = 1'b1;
                        mem_addr = bus.d_addr;
                        if (d_st4)      mem_ctrl = `MEM_STORE4;
                        else if (d_sub) state_nx = RMW_WR;
                    end else if (bus.if_req) begin
                        gnt_i    = 1'b1;
                        mem_addr = bus.if_addr;
                    end
                end
                RMW_WR: begin
                    mem_ctrl  = `MEM_STORE4;
                    mem_addr  = lat_addr;
                    mem_wdata = merged;
                    state_nx  = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Sub-word store: capture the old word and the request for the write-back cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr  <= 32'h0;
            lat_word  <= 32'h0;
            lat_wdata <= 16'h0;
            lat_byte  <= 1'b0;
        end else if (gnt_d && d_sub) begin
            lat_addr  <= bus.d_addr;
            lat_word  <= bus.mem_rdata;
            lat_wdata <= bus.d_wdata[15:0];
            lat_byte  <= (bus.d_ctrl == `MEM_STORE1);
        end
    end

    assign lane_sel = lat_byte ? (4'b0001 << lat_addr[1:0])
                               : (lat_addr[1] ? 4'b1100 : 4'b0011);

    for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
        assign merged[8*b +: 8] = !lane_sel[b] ? lat_word[8*b +: 8] :
                                  lat_byte     ? lat_wdata[7:0]     :
                                                 lat_wdata[8*(b%2) +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= 32'h0;
            d_rdata   <= 32'h0;
        end else begin
            if_rvalid <= gnt_i;
            d_rvalid  <= gnt_d && d_load;
            if (gnt_i)           if_rdata <= bus.mem_rdata;
            if (gnt_d && d_load) d_rdata  <= bus.mem_rdata;
        end
    end

    assign bus.if_gnt    = gnt_i;
    assign bus.d_gnt     = gnt_d;
    assign bus.if_rvalid = if_rvalid;
    assign bus.if_rdata  = if_rdata;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.d_rdata   = d_rdata;
    assign bus.mem_ctrl  = mem_ctrl;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus random single-port traffic
// against a word-array reference model; a monitor checks every rvalid against a queue.
`timescale 1ns/1ps

`ifndef MEM_STORE1
`define MEM_STORE1 4'h5
`endif
`ifndef MEM_STORE2
`define MEM_STORE2 4'h6
`endif
`ifndef MEM_STORE4
`define MEM_STORE4 4'h7
`endif

module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_arbiter_if bus();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Memory attached to the arbiter, and the independent reference model.
    logic [31:0] tmem    [64];
    logic [31:0] ref_mem [64];
    assign bus.mem_rdata = tmem[bus.mem_addr[7:2]];
    always @(posedge clk) if (bus.mem_ctrl == `MEM_STORE4) tmem[bus.mem_addr[7:2]] <= bus.mem_wdata;

    typedef struct { logic [31:0] data; int cyc; } exp_t;
    exp_t ifq[$], dq[$];
    exp_t e_if, e_d;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.if_rvalid) begin
                if (ifq.size() == 0) chk("if_rvalid_unexpected", 32'd1, 32'd0);
                else begin
                    e_if = ifq.pop_front();
                    chk("if_rdata", bus.if_rdata, e_if.data);
                    chk("if_rvalid_cycle", 32'(cyc), 32'(e_if.cyc));
                end
            end else if (ifq.size() > 0 && ifq[0].cyc <= cyc) begin
                chk("if_rvalid_missing", 32'd0, 32'd1);
                void'(ifq.pop_front());
            end
            if (bus.d_rvalid) begin
                if (dq.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
                else begin
                    e_d = dq.pop_front();
                    chk("d_rdata", bus.d_rdata, e_d.data);
                    chk("d_rvalid_cycle", 32'(cyc), 32'(e_d.cyc));
                end
            end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
                chk("d_rvalid_missing", 32'd0, 32'd1);
                void'(dq.pop_front());
            end
        end
    end

    function automatic logic [31:0] apply_store(input logic [31:0] word, input logic [3:0] ctrl,
                                                input logic [31:0] addr, input logic [31:0] wdata);
        int sh;
        if (ctrl == `MEM_STORE1) begin
            sh = 8 * int'(addr[1:0]);
            return (word & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
        end
        if (ctrl == `MEM_STORE2) begin
            sh = addr[1] ? 16 : 0;
            return (word & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
        end
        return wdata;
    endfunction

    function automatic bit is_store(input logic [3:0] c);
        return c == `MEM_STORE1 || c == `MEM_STORE2 || c == `MEM_STORE4;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called at posedge+1; returns at posedge+1 after the granting edge.
    task automatic d_op(input logic [3:0] ctrl, input logic [31:0] addr, input logic [31:0] wdata,
                        output int waited);
        bit got = 0;
        bus.d_req = 1'b1; bus.d_ctrl = ctrl; bus.d_addr = addr; bus.d_wdata = wdata;
        waited = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.d_gnt) got = 1; else waited++;
        end
        if (!got) chk("d_gnt_timeout", 32'd0, 32'd1);
        else if (is_store(ctrl)) ref_mem[addr[7:2]] = apply_store(ref_mem[addr[7:2]], ctrl, addr, wdata);
        else dq.push_back('{ref_mem[addr[7:2]], cyc + 1});
        @(posedge clk); #1;
        bus.d_req = 1'b0; bus.d_ctrl = 4'h0;
    endtask

    task automatic f_op(input logic [31:0] addr, output int waited);
        bit got = 0;
        bus.if_req = 1'b1; bus.if_addr = addr;
        waited = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.if_gnt) got = 1; else waited++;
        end
        if (!got) chk("if_gnt_timeout", 32'd0, 32'd1);
        else ifq.push_back('{ref_mem[addr[7:2]], cyc + 1});
        @(posedge clk); #1;
        bus.if_req = 1'b0;
    endtask

    task automatic check_rmw();
        @(negedge clk);
        chk("rmw_mem_ctrl", 32'(bus.mem_ctrl), 32'(`MEM_STORE4));
        chk("rmw_no_d_gnt", 32'(bus.d_gnt), 32'd0);
        chk("rmw_no_if_gnt", 32'(bus.if_gnt), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_if_gnt"}, 32'(bus.if_gnt), 32'd0);
        chk({tag, "_d_gnt"}, 32'(bus.d_gnt), 32'd0);
        chk({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
        chk({tag, "_d_rvalid"}, 32'(bus.d_rvalid), 32'd0);
        chk({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
        chk({tag, "_d_rdata"}, bus.d_rdata, 32'd0);
        chk({tag, "_mem_ctrl"}, 32'(bus.mem_ctrl), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, w2, op;
        logic [31:0] a, dat, old;
        logic [3:0] lc;
        logic [1:0] exp_g;

        for (int i = 0; i < 64; i++) begin tmem[i] = 32'h0; ref_mem[i] = 32'h0; end
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_ctrl = 4'h0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        @(posedge clk); #1;

        // Requests during reset must not reach memory or be granted.
        bus.d_req = 1'b1; bus.d_ctrl = `MEM_STORE4; bus.if_req = 1'b1;
        idle(2);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #1;
        bus.d_req = 1'b0; bus.d_ctrl = 4'h0; bus.if_req = 1'b0;
        rst = 1'b0;
        idle(1);

        d_op(`MEM_STORE4, 32'h10, 32'hDEADBEEF, w);
        chk("store4_gnt_wait", 32'(w), 32'd0);
        d_op(4'h1, 32'h10, 32'h0, w);
        chk("load_gnt_wait", 32'(w), 32'd0);
        chk("load_0x10", bus.d_rdata, 32'hDEADBEEF);

        d_op(`MEM_STORE4, 32'h04, 32'h5A5A5A5A, w);
        d_op(4'h2, 32'h404, 32'h0, w);
        chk("load_wrap_0x404", bus.d_rdata, 32'h5A5A5A5A);

        d_op(`MEM_STORE4, 32'h20, 32'h11223344, w);
        d_op(`MEM_STORE1, 32'h22, 32'h000000AB, w);
        fork check_rmw(); d_op(4'h1, 32'h20, 32'h0, w2); join
        chk("store1_load_wait", 32'(w2), 32'd1);
        chk("store1_merge", bus.d_rdata, 32'h11AB3344);
        d_op(`MEM_STORE2, 32'h20, 32'h0000CAFE, w);
        fork check_rmw(); d_op(4'h1, 32'h20, 32'h0, w2); join
        chk("store2_merge", bus.d_rdata, 32'h11ABCAFE);

        d_op(`MEM_STORE2, 32'h27, 32'hFFFF1234, w);
        fork check_rmw(); f_op(32'h24, w2); join
        chk("fetch_after_rmw_wait", 32'(w2), 32'd1);
        idle(1);
        chk("store2_hi_fetch", bus.if_rdata, 32'h12340000);

        // Reset in the write-back cycle aborts the sub-word store.
        old = ref_mem[12];
        d_op(`MEM_STORE1, 32'h30, 32'h000000FF, w);
        rst = 1'b1;
        ref_mem[12] = old;
        @(negedge clk);
        chk("abort_mem_ctrl", 32'(bus.mem_ctrl), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_zero_outputs("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        d_op(4'h3, 32'h30, 32'h0, w);
        chk("abort_word_0x30", bus.d_rdata, 32'h0);

        for (int n = 0; n < 80; n++) begin
            op  = int'($urandom_range(0, 4));
            a   = $urandom;
            dat = $urandom;
            lc  = 4'($urandom_range(1, 4));
            case (op)
                0: f_op(a, w);
                1: d_op(lc, a, dat, w);
                2: d_op(`MEM_STORE1, a, dat, w);
                3: d_op(`MEM_STORE2, a, dat, w);
                default: d_op(`MEM_STORE4, a, dat, w);
            endcase
            idle(int'($urandom_range(0, 1)));
        end

        // Contention: both ports held for four cycles from a fresh reset.
        idle(2);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        bus.d_req = 1'b1; bus.d_ctrl = 4'h1; bus.d_addr = 32'h10; bus.if_req = 1'b1; bus.if_addr = 32'h24;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
`ifdef MEM_ARB_RR_EN
            exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            chk($sformatf("arb_cycle%0d", k), 32'({bus.if_gnt, bus.d_gnt}), 32'(exp_g));
            if (exp_g[0]) dq.push_back('{ref_mem[4], cyc + 1});
            else          ifq.push_back('{ref_mem[9], cyc + 1});
            @(posedge clk); #1;
        end
        bus.d_req = 1'b0; bus.if_req = 1'b0;

        idle(3);
        chk("ifq_drained", 32'(ifq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
